demux_1x4_32b_buf: RTL and testbench

//  Registered 1-to-4 demultiplexer with per-channel holding buffers: the return path of the 4x1 result mux.
//  A single producer (ALU result bus / sequential multiplier output) presents one word plus a 2-bit destination.
//  The word is latched into one of four output buffers. Each buffer is drained by its own consumer using valid/ack.

---
 rtl/demux_1x4_32b_buf.sv | 117 +++++++++++
 tb/tb_demux_1x4_32b_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_32b_buf.sv
// demux_1x4_32b_buf
//   Registered 1-to-4 demultiplexer with per-channel holding buffers. One
//   producer offers a word plus a 2-bit destination {s1,s0}; the word is
//   latched into the addressed buffer. Each buffer is drained by its own
//   consumer through out_valid/out_ack. The producer is back-pressured
//   whenever the addressed buffer is full and not being acked.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data, s0, s1   word to route and destination select (channel = {s1,s0})
//   in_valid          producer offers a word this cycle
//   in_ready          addressed buffer can take the word (combinational)
//   out0..out3        buffer contents
//   out_valid         bit k = buffer k holds an unconsumed word
//   out_ack           bit k = consumer k takes buffer k this cycle
//   err_clr           synchronous clear of err_stall
//   err_stall         sticky back-pressure flag (a new stall beats err_clr)
//   xfer_cnt          count of accepted words, wraps modulo 2^16
module demux_1x4_32b_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  input  logic             err_clr,
  output logic             err_stall,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state_q [4];
  ch_state_t        state_d [4];
  logic [WIDTH-1:0] buf_q   [4];

  logic [1:0] sel;
  logic       accept;
  logic       stall;

  assign sel = {s1, s0};

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      out_valid[k] = (state_q[k] == FULL);
    end
  end

  // An ack on the addressed channel frees its slot in the same cycle, so a
  // full buffer being drained can take the next word without a bubble.
  assign in_ready = ~out_valid[sel] | out_ack[sel];
  assign accept   = in_valid & in_ready;
  assign stall    = in_valid & ~in_ready;

  // Next-state: accept wins over ack, so accept+ack keeps the channel FULL.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      if (accept && (sel == 2'(k))) begin
        state_d[k] = FULL;
      end else if (out_ack[k] && (state_q[k] == FULL)) begin
        state_d[k] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        buf_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        if (accept && (sel == 2'(k))) begin
          buf_q[k] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= '0;
      err_stall <= 1'b0;
    end else begin
      if (accept) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (stall) begin
        err_stall <= 1'b1;
      end else if (err_clr) begin
        err_stall <= 1'b0;
      end
    end
  end

  assign out0 = buf_q[0];
  assign out1 = buf_q[1];
  assign out2 = buf_q[2];
  assign out3 = buf_q[3];

endmodule

// File: tb/tb_demux_1x4_32b_buf.sv
// tb_demux_1x4_32b_buf
//   Directed bench for demux_1x4_32b_buf. A behavioural model tracks buffer
//   contents, valid bits, the transfer count and the sticky stall flag; each
//   accepted word is also queued and popped one cycle later against the
//   addressed output.
module tb_demux_1x4_32b_buf;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        s0;
  logic        s1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic        err_clr;
  logic        err_stall;
  logic [15:0] xfer_cnt;

  demux_1x4_32b_buf #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .s0        (s0),
    .s1        (s1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .err_clr   (err_clr),
    .err_stall (err_stall),
    .xfer_cnt  (xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_cmp;
  int unsigned n_bad;

  // Model state
  logic [31:0] exp_data [4];
  logic [3:0]  exp_valid;
  logic [15:0] exp_cnt;
  logic        exp_err;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_item_t;
  sb_item_t sb_q[$];

  function automatic logic [31:0] get_out(input logic [1:0] ch);
    case (ch)
      2'd0:    return out0;
      2'd1:    return out1;
      2'd2:    return out2;
      default: return out3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " out0"}, out0, exp_data[0]);
    chk({tag, " out1"}, out1, exp_data[1]);
    chk({tag, " out2"}, out2, exp_data[2]);
    chk({tag, " out3"}, out3, exp_data[3]);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    chk({tag, " err_stall"}, 32'(err_stall), 32'(exp_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_data[i] = '0;
    exp_valid = '0;
    exp_cnt   = '0;
    exp_err   = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: drive at negedge, check in_ready, update model across
  // the posedge, then check outputs (full check only when do_chk is set).
  task automatic step(input string tag, input logic v, input logic [1:0] ch,
                      input logic [31:0] d, input logic [3:0] ack,
                      input logic clr, input bit do_chk);
    logic     rdy;
    logic     acc;
    sb_item_t it;
    @(negedge clk);
    in_valid = v;
    {s1, s0} = ch;
    in_data  = d;
    out_ack  = ack;
    err_clr  = clr;
    #1;
    rdy = ~exp_valid[ch] | ack[ch];
    if (do_chk) chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    acc = v & rdy;
    for (int k = 0; k < 4; k++) begin
      if (ack[k] && exp_valid[k] && !(acc && ch == 2'(k))) exp_valid[k] = 1'b0;
    end
    if (acc) begin
      exp_data[ch]  = d;
      exp_valid[ch] = 1'b1;
      exp_cnt       = exp_cnt + 16'd1;
      sb_q.push_back('{ch: ch, data: d});
    end
    if (v && !rdy) exp_err = 1'b1;
    else if (clr)  exp_err = 1'b0;
    @(posedge clk);
    #1;
    if (acc) begin
      it = sb_q.pop_front();
      if (do_chk) chk({tag, " sb_word"}, get_out(it.ch), it.data);
    end
    if (do_chk) chk_all(tag);
    in_valid = 1'b0;
    out_ack  = '0;
    err_clr  = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_data  = '0;
    s0       = 1'b0;
    s1       = 1'b0;
    in_valid = 1'b0;
    out_ack  = '0;
    err_clr  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("por");
    rst_n = 1'b1;

    // Routing to each channel, no acks
    step("route0", 1'b1, 2'd0, 32'd0,  4'b0000, 1'b0, 1);
    step("route1", 1'b1, 2'd1, 32'd1,  4'b0000, 1'b0, 1);
    step("route2", 1'b1, 2'd2, 32'd8,  4'b0000, 1'b0, 1);
    step("route3", 1'b1, 2'd3, 32'd16, 4'b0000, 1'b0, 1);

    // Back-pressure on full ch2, then clear the sticky flag
    step("stall2", 1'b1, 2'd2, 32'hDEAD, 4'b0000, 1'b0, 1);
    step("errclr", 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1);

    // Stall and err_clr on the same edge: set wins
    step("stallclr", 1'b1, 2'd3, 32'hBEEF, 4'b0000, 1'b1, 1);
    step("errclr2", 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1);

    // Select/data changes with in_valid low have no effect
    step("idle_sel", 1'b0, 2'd1, 32'h1234_5678, 4'b0000, 1'b0, 1);

    // Pass-through: ack and accept on ch1 together
    step("pass1", 1'b1, 2'd1, 32'd7, 4'b0010, 1'b0, 1);

    // Drain ch3, then ack on ch0 twice (second time it is empty)
    step("drain3", 1'b0, 2'd0, 32'h0, 4'b1000, 1'b0, 1);
    step("drain0", 1'b0, 2'd0, 32'h0, 4'b0001, 1'b0, 1);
    step("ackempty", 1'b0, 2'd0, 32'h0, 4'b1001, 1'b0, 1);

    // Accept to ch0 while all four consumers ack
    step("acc_allack", 1'b1, 2'd0, 32'hCAFE_F00D, 4'b1111, 1'b0, 1);

    // Fill everything, then assert reset mid-cycle and check before next edge
    step("fill1", 1'b1, 2'd1, 32'h11, 4'b0000, 1'b0, 1);
    step("fill2", 1'b1, 2'd2, 32'h22, 4'b0000, 1'b0, 1);
    step("fill3", 1'b1, 2'd3, 32'h33, 4'b0000, 1'b0, 1);
    step("fillstall", 1'b1, 2'd3, 32'h44, 4'b0000, 1'b0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: run up to 16'hFFFF with err_stall set, then one more accept
    step("prestall0", 1'b1, 2'd0, 32'h1, 4'b0000, 1'b0, 1);
    step("prestall1", 1'b1, 2'd0, 32'h2, 4'b0000, 1'b0, 1);
    while (exp_cnt != 16'hFFFF) begin
      step("wrap_run", 1'b1, 2'd0, 32'(exp_cnt), 4'b0001, 1'b0, 0);
    end
    chk_all("pre_wrap");
    step("wrap", 1'b1, 2'd0, 32'hFFFF_0000, 4'b0001, 1'b0, 1);
    chk("wrap_cnt_zero", 32'(xfer_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
